// File: rtl/uart_core_sc.sv
// Single-clock UART transceiver: independent TX and RX state machines timed by
// bit-period counters on the system clock, with a 2-flop RX synchronizer,
// start-bit glitch rejection and per-frame parity/framing error flags.
// Optional build macro UART_CORE_LOOPBACK_EN adds i_loopback, which routes the
// internal TX line into the RX path and holds the pin high.
module uart_core_sc #(
   parameter int unsigned P_SYSTEM_CLK      = 50_000_000,
   parameter int unsigned P_UART_BUADRATE   = 9600,
   parameter int unsigned P_UART_DATA_WIDTH = 8,
   parameter int unsigned P_UART_STOP_WIDTH = 1,
   parameter int unsigned P_UART_CHECK      = 0
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
`ifdef UART_CORE_LOOPBACK_EN
   input  logic                         i_loopback,
`endif
   input  logic                         i_uart_rx,
   output logic                         o_uart_tx,
   input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
   input  logic                         i_user_tx_valid,
   output logic                         o_user_tx_ready,
   output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
   output logic                         o_user_rx_valid,
   output logic                         o_rx_parity_err,
   output logic                         o_rx_frame_err
);

   localparam int unsigned DW         = P_UART_DATA_WIDTH;
   localparam int unsigned P_BIT_CYC  = P_SYSTEM_CLK / P_UART_BUADRATE;
   localparam int unsigned P_HALF_CYC = P_BIT_CYC / 2;
   // Wide enough for the longest state (two stop bits on TX).
   localparam int unsigned LP_CNT_W   = $clog2(2 * P_BIT_CYC);

   localparam logic [LP_CNT_W-1:0] LP_BIT_LAST  = LP_CNT_W'(P_BIT_CYC - 1);
   localparam logic [LP_CNT_W-1:0] LP_HALF_LAST = LP_CNT_W'(P_HALF_CYC - 1);
   localparam logic [LP_CNT_W-1:0] LP_STOP_LAST = LP_CNT_W'(P_UART_STOP_WIDTH * P_BIT_CYC - 1);
   localparam logic [3:0]          LP_DATA_LAST = 4'(DW - 1);

   if (P_BIT_CYC < 4) begin : g_bit_cyc_check
      $error("uart_core_sc: P_SYSTEM_CLK / P_UART_BUADRATE must be at least 4");
   end

   typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

   tx_state_e               tx_state_q, tx_state_d;
   logic [LP_CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
   logic [3:0]              tx_bit_q, tx_bit_d;
   logic [DW-1:0]           tx_shift_q, tx_shift_d;
   logic                    tx_par_q, tx_par_d;
   logic                    tx_line_q, tx_line_d;
   logic                    tx_ready_q, tx_ready_d;

   rx_state_e               rx_state_q, rx_state_d;
   logic [LP_CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
   logic [3:0]              rx_bit_q, rx_bit_d;
   logic [DW-1:0]           rx_shift_q, rx_shift_d;
   logic                    rx_par_bad_q, rx_par_bad_d;
   logic [DW-1:0]           rx_data_q, rx_data_d;
   logic                    rx_valid_q, rx_valid_d;
   logic                    rx_perr_q, rx_perr_d;
   logic                    rx_ferr_q, rx_ferr_d;
   logic                    rx_meta_q, rx_sync_q, rx_prev_q;
   logic                    rx_src;

`ifdef UART_CORE_LOOPBACK_EN
   assign rx_src    = i_loopback ? tx_line_q : i_uart_rx;
   assign o_uart_tx = i_loopback | tx_line_q;
`else
   assign rx_src    = i_uart_rx;
   assign o_uart_tx = tx_line_q;
`endif

   assign o_user_tx_ready = tx_ready_q;
   assign o_user_rx_data  = rx_data_q;
   assign o_user_rx_valid = rx_valid_q;
   assign o_rx_parity_err = rx_perr_q;
   assign o_rx_frame_err  = rx_ferr_q;

   // TX next-state: line level is registered so it changes on the state edge.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_line_d  = tx_line_q;
      tx_ready_d = tx_ready_q;
      unique case (tx_state_q)
         TxIdle: begin
            tx_line_d = 1'b1;
            if (i_user_tx_valid && tx_ready_q) begin
               tx_shift_d = i_user_tx_data;
               tx_par_d   = (P_UART_CHECK == 1) ? ~^i_user_tx_data : ^i_user_tx_data;
               tx_ready_d = 1'b0;
               tx_line_d  = 1'b0;
               tx_cnt_d   = '0;
               tx_state_d = TxStart;
            end else begin
               tx_ready_d = 1'b1;
            end
         end
         TxStart: begin
            if (tx_cnt_q == LP_BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_line_d  = tx_shift_q[0];
               tx_state_d = TxData;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TxData: begin
            if (tx_cnt_q == LP_BIT_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == LP_DATA_LAST) begin
                  if (P_UART_CHECK != 0) begin
                     tx_line_d  = tx_par_q;
                     tx_state_d = TxParity;
                  end else begin
                     tx_line_d  = 1'b1;
                     tx_state_d = TxStop;
                  end
               end else begin
                  tx_bit_d   = tx_bit_q + 1'b1;
                  tx_shift_d = tx_shift_q >> 1;
                  tx_line_d  = tx_shift_q[1];
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TxParity: begin
            if (tx_cnt_q == LP_BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_line_d  = 1'b1;
               tx_state_d = TxStop;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TxStop: begin
            if (tx_cnt_q == LP_STOP_LAST) begin
               tx_cnt_d   = '0;
               tx_ready_d = 1'b1;
               tx_state_d = TxIdle;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         default: tx_state_d = TxIdle;
      endcase
   end

   // TX state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_line_q  <= 1'b1;
         tx_ready_q <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         tx_line_q  <= tx_line_d;
         tx_ready_q <= tx_ready_d;
      end
   end

   // RX synchronizer plus one more flop of history for falling-edge detection.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_src;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   // RX next-state: half-bit start check, then mid-bit sampling of each bit.
   always_comb begin
      rx_state_d   = rx_state_q;
      rx_cnt_d     = rx_cnt_q;
      rx_bit_d     = rx_bit_q;
      rx_shift_d   = rx_shift_q;
      rx_par_bad_d = rx_par_bad_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      rx_perr_d    = 1'b0;
      rx_ferr_d    = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            if (rx_prev_q && !rx_sync_q) begin
               rx_cnt_d   = '0;
               rx_state_d = RxStart;
            end
         end
         RxStart: begin
            if (rx_cnt_q == LP_HALF_LAST) begin
               rx_cnt_d = '0;
               if (rx_sync_q) begin
                  // Line back high before mid start bit: glitch.
                  rx_state_d = RxIdle;
               end else begin
                  rx_bit_d     = '0;
                  rx_par_bad_d = 1'b0;
                  rx_state_d   = RxData;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RxData: begin
            if (rx_cnt_q == LP_BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[DW-1:1]};
               if (rx_bit_q == LP_DATA_LAST) begin
                  rx_state_d = (P_UART_CHECK != 0) ? RxParity : RxStop;
               end else begin
                  rx_bit_d = rx_bit_q + 1'b1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RxParity: begin
            if (rx_cnt_q == LP_BIT_LAST) begin
               rx_cnt_d     = '0;
               rx_par_bad_d = rx_sync_q != ((P_UART_CHECK == 1) ? ~^rx_shift_q : ^rx_shift_q);
               rx_state_d   = RxStop;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RxStop: begin
            if (rx_cnt_q == LP_BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_data_d  = rx_shift_q;
               rx_valid_d = 1'b1;
               rx_perr_d  = (P_UART_CHECK != 0) && rx_par_bad_q;
               rx_ferr_d  = !rx_sync_q;
               rx_state_d = RxIdle;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   // RX state register and registered user outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_state_q   <= RxIdle;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         rx_par_bad_q <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         rx_perr_q    <= 1'b0;
         rx_ferr_q    <= 1'b0;
      end else begin
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         rx_par_bad_q <= rx_par_bad_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         rx_perr_q    <= rx_perr_d;
         rx_ferr_q    <= rx_ferr_d;
      end
   end

endmodule

// File: tb/tb_uart_core_sc.sv
// Testbench for uart_core_sc: one instance without parity and one with even
// parity, both at 16 clocks per bit. Expected line waveforms and received
// frames come from a bit-list model of the UART frame format.
module tb_uart_core_sc;

   localparam int BIT = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       loopback;
   logic       rx0, rx1;
   logic       tx0, tx1;
   logic [7:0] txd0, txd1;
   logic       txv0, txv1;
   logic       rdy0, rdy1;
   logic [7:0] rxd0, rxd1;
   logic       rxv0, rxv1;
   logic       pe0, pe1, fe0, fe1;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int stray    = 0;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      int         cyc;
   } rx_ev_t;

   rx_ev_t q0[$];
   rx_ev_t q1[$];

   always #5 clk = ~clk;

   uart_core_sc #(
      .P_SYSTEM_CLK     (1_600_000),
      .P_UART_BUADRATE  (100_000),
      .P_UART_DATA_WIDTH(8),
      .P_UART_STOP_WIDTH(1),
      .P_UART_CHECK     (0)
   ) u_dut (
      .i_clk          (clk),
      .i_rst          (rst),
`ifdef UART_CORE_LOOPBACK_EN
      .i_loopback     (loopback),
`endif
      .i_uart_rx      (rx0),
      .o_uart_tx      (tx0),
      .i_user_tx_data (txd0),
      .i_user_tx_valid(txv0),
      .o_user_tx_ready(rdy0),
      .o_user_rx_data (rxd0),
      .o_user_rx_valid(rxv0),
      .o_rx_parity_err(pe0),
      .o_rx_frame_err (fe0)
   );

   uart_core_sc #(
      .P_SYSTEM_CLK     (1_600_000),
      .P_UART_BUADRATE  (100_000),
      .P_UART_DATA_WIDTH(8),
      .P_UART_STOP_WIDTH(1),
      .P_UART_CHECK     (2)
   ) u_dut_par (
      .i_clk          (clk),
      .i_rst          (rst),
`ifdef UART_CORE_LOOPBACK_EN
      .i_loopback     (1'b0),
`endif
      .i_uart_rx      (rx1),
      .o_uart_tx      (tx1),
      .i_user_tx_data (txd1),
      .i_user_tx_valid(txv1),
      .o_user_tx_ready(rdy1),
      .o_user_rx_data (rxd1),
      .o_user_rx_valid(rxv1),
      .o_rx_parity_err(pe1),
      .o_rx_frame_err (fe1)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Record every RX pulse; error flags outside a pulse are counted as stray.
   always @(negedge clk) begin
      if (rxv0 === 1'b1) q0.push_back('{rxd0, pe0, fe0, cyc});
      else if (pe0 !== 1'b0 || fe0 !== 1'b0) stray <= stray + 1;
      if (rxv1 === 1'b1) q1.push_back('{rxd1, pe1, fe1, cyc});
      else if (pe1 !== 1'b0 || fe1 !== 1'b0) stray <= stray + 1;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: observed no finish, required finish before 5ms");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_rx(input bit sel, input logic v);
      if (sel) rx1 = v;
      else rx0 = v;
   endtask

   task automatic set_tx(input bit sel, input logic v, input logic [7:0] d);
      if (sel) begin
         txv1 = v;
         txd1 = d;
      end else begin
         txv0 = v;
         txd0 = d;
      end
   endtask

   // Frame as a list of line levels: start, data LSB first, even parity (par
   // instance only), stop.
   function automatic logic even_par(input logic [7:0] d);
      return ($countones(d) % 2) == 1;
   endfunction

   // Pulse lands 1 cycle after the mid-stop sample plus 2 synchronizer cycles.
   function automatic int rx_lat(input bit sel);
      return (sel ? 10 : 9) * BIT + BIT / 2 + 3;
   endfunction

   task automatic drive_rx(input bit sel, input logic [7:0] d, input logic pbit,
                           input logic stop, output int fall);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (sel) bits.push_back(pbit);
      bits.push_back(stop);
      fall = cyc;
      foreach (bits[i]) begin
         set_rx(sel, bits[i]);
         tick(BIT);
      end
      set_rx(sel, 1'b1);
   endtask

   task automatic verify_rx(input bit sel, input logic [7:0] d, input logic pe, input logic fe,
                            input int exp_cyc, input string tag);
      rx_ev_t ev;
      int n;
      n = sel ? q1.size() : q0.size();
      check({tag, "_present"}, 32'(n != 0), 1);
      if (n != 0) begin
         ev = sel ? q1.pop_front() : q0.pop_front();
         check({tag, "_data"}, ev.d, d);
         check({tag, "_perr"}, ev.pe, pe);
         check({tag, "_ferr"}, ev.fe, fe);
         check({tag, "_cycle"}, ev.cyc, exp_cyc);
      end
   endtask

   task automatic tx_frame(input bit sel, input logic [7:0] d, input bit lb, input string tag,
                           output int acc);
      logic bits[$];
      int   w;
      bit   bit_ok, busy_ok;
      w = 0;
      while (((sel ? rdy1 : rdy0) !== 1'b1) && w < 1000) begin
         tick(1);
         w++;
      end
      check({tag, "_ready"}, 32'((sel ? rdy1 : rdy0) === 1'b1), 1);
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (sel) bits.push_back(even_par(d));
      bits.push_back(1'b1);
      set_tx(sel, 1'b1, d);
      tick(1);
      acc = cyc;
      set_tx(sel, 1'b0, 8'($urandom));
      bit_ok  = 1'b1;
      busy_ok = 1'b1;
      for (int k = 0; k < bits.size() * BIT; k++) begin
         if ((sel ? tx1 : tx0) !== (lb ? 1'b1 : bits[k / BIT])) bit_ok = 1'b0;
         if ((sel ? rdy1 : rdy0) !== 1'b0) busy_ok = 1'b0;
         if (k % BIT == BIT - 1) begin
            check($sformatf("%s_bit%0d", tag, k / BIT), 32'(bit_ok), 1);
            bit_ok = 1'b1;
         end
         // Valid while not ready must be ignored.
         if (k == 20) set_tx(sel, 1'b1, ~d);
         if (k == 60) set_tx(sel, 1'b0, 8'($urandom));
         tick(1);
      end
      check({tag, "_busy"}, 32'(busy_ok), 1);
      check({tag, "_ready_back"}, sel ? rdy1 : rdy0, 1);
      check({tag, "_idle_line"}, sel ? tx1 : tx0, 1);
   endtask

   initial begin
      int         f, acc;
      int         falls[3];
      logic [7:0] d, ds[3];

      rst      = 1'b1;
      loopback = 1'b0;
      rx0      = 1'b1;
      rx1      = 1'b1;
      txv0     = 1'b0;
      txv1     = 1'b0;
      txd0     = '0;
      txd1     = '0;
      tick(3);

      // Reset state.
      check("rst_tx0", tx0, 1);
      check("rst_rdy0", rdy0, 0);
      check("rst_rxd0", rxd0, 0);
      check("rst_rxv0", rxv0, 0);
      check("rst_pe0", pe0, 0);
      check("rst_fe0", fe0, 0);
      check("rst_tx1", tx1, 1);
      check("rst_rdy1", rdy1, 0);
      check("rst_rxv1", rxv1, 0);
      rst = 1'b0;
      tick(1);
      check("rdy0_after_rst", rdy0, 1);
      check("rdy1_after_rst", rdy1, 1);

      // TX frames.
      tx_frame(0, 8'hA5, 0, "tx_a5", acc);
      for (int i = 0; i < 3; i++) tx_frame(0, 8'($urandom), 0, $sformatf("tx_rnd%0d", i), acc);
      for (int i = 0; i < 2; i++) tx_frame(1, 8'($urandom), 0, $sformatf("txp_rnd%0d", i), acc);

      // RX ideal frame.
      drive_rx(0, 8'h3C, 1'b0, 1'b1, f);
      tick(4 * BIT);
      verify_rx(0, 8'h3C, 0, 0, f + rx_lat(0), "rx_3c");
      check("rx_3c_single", q0.size(), 0);

      // Start-bit glitch, then a good frame.
      rx0 = 1'b0;
      tick(5);
      rx0 = 1'b1;
      tick(3 * BIT);
      check("glitch_no_pulse", q0.size(), 0);
      drive_rx(0, 8'h81, 1'b0, 1'b1, f);
      tick(4 * BIT);
      verify_rx(0, 8'h81, 0, 0, f + rx_lat(0), "rx_81");

      // Back-to-back random frames, one stop bit each.
      for (int i = 0; i < 3; i++) begin
         ds[i] = 8'($urandom);
         drive_rx(0, ds[i], 1'b0, 1'b1, falls[i]);
      end
      tick(4 * BIT);
      for (int i = 0; i < 3; i++)
         verify_rx(0, ds[i], 0, 0, falls[i] + rx_lat(0), $sformatf("b2b%0d", i));
      check("b2b_count", q0.size(), 0);

      // Even-parity instance: bad parity, bad stop, good frame.
      drive_rx(1, 8'h07, 1'b0, 1'b1, f);
      tick(4 * BIT);
      verify_rx(1, 8'h07, 1, 0, f + rx_lat(1), "par_bad");
      d = 8'($urandom);
      drive_rx(1, d, even_par(d), 1'b0, f);
      tick(4 * BIT);
      verify_rx(1, d, 0, 1, f + rx_lat(1), "stop_bad");
      d = 8'($urandom);
      drive_rx(1, d, even_par(d), 1'b1, f);
      tick(4 * BIT);
      verify_rx(1, d, 0, 0, f + rx_lat(1), "par_good");
      d = 8'($urandom);
      drive_rx(1, d, ~even_par(d), 1'b1, f);
      tick(4 * BIT);
      verify_rx(1, d, 1, 0, f + rx_lat(1), "par_rnd_bad");

      // TX on one instance while the other receives.
      d = 8'($urandom);
      fork
         tx_frame(1, 8'($urandom), 0, "dup_tx", acc);
         drive_rx(0, d, 1'b0, 1'b1, f);
      join
      tick(4 * BIT);
      verify_rx(0, d, 0, 0, f + rx_lat(0), "dup_rx");

      // Reset in the middle of a TX frame and an RX frame.
      set_tx(0, 1'b1, 8'h00);
      tick(1);
      set_tx(0, 1'b0, 8'h00);
      rx1 = 1'b0;
      tick(50);
      check("pre_rst_tx_low", tx0, 0);
      rst = 1'b1;
      tick(1);
      check("mid_rst_tx", tx0, 1);
      check("mid_rst_rdy", rdy0, 0);
      rx1 = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      check("post_rst_rdy", rdy0, 1);
      tick(12 * BIT);
      check("post_rst_no_rx0", q0.size(), 0);
      check("post_rst_no_rx1", q1.size(), 0);
      check("post_rst_tx_idle", tx0, 1);

`ifdef UART_CORE_LOOPBACK_EN
      loopback = 1'b1;
      tx_frame(0, 8'h5A, 1, "lb_tx", acc);
      tick(2 * BIT);
      verify_rx(0, 8'h5A, 0, 0, acc + rx_lat(0), "lb_rx");
      loopback = 1'b0;
`endif

      tick(2 * BIT);
      check("stray_err_flags", stray, 0);
      check("final_q0_empty", q0.size(), 0);
      check("final_q1_empty", q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
